// File: rtl/writeback_arbiter_pkg.sv
// Shared encodings and defaults for the writeback arbiter slice.
package writeback_arbiter_pkg;

  localparam int unsigned WB_WIDTH_DFLT        = 32;
  localparam int unsigned WB_DEPTH_DFLT        = 5;
  localparam int unsigned WB_FIFO_LOG2_DFLT    = 2;
  localparam int unsigned WB_STARVE_LIMIT_DFLT = 4;

  localparam logic WB_ENABLE  = 1'b1;
  localparam logic WB_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_LU   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Synchronous FIFO buffering long-latency results; no fall-through, full/empty from count.
module writeback_arbiter_fifo #(
  parameter int unsigned DATA_W = 37,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int unsigned ENTRIES = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [ENTRIES];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(ENTRIES));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline and long-latency results onto the RF write port with a starvation guard.
// Optional forwarding of the in-flight RF write is enabled by defining WB_FORWARD_EN.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH           = WB_WIDTH_DFLT,
  parameter int unsigned DEPTH           = WB_DEPTH_DFLT,
  parameter int unsigned FIFO_DEPTH_LOG2 = WB_FIFO_LOG2_DFLT,
  parameter int unsigned STARVE_LIMIT    = WB_STARVE_LIMIT_DFLT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pipe_valid_i,
  input  logic [DEPTH-1:0]           pipe_index_i,
  input  logic [WIDTH-1:0]           pipe_data_i,
  output logic                       pipe_stall_o,
  input  logic                       lu_valid_i,
  output logic                       lu_ready_o,
  input  logic [DEPTH-1:0]           lu_index_i,
  input  logic [WIDTH-1:0]           lu_data_i,
  output logic                       rf_write_enable_o,
  output logic [DEPTH-1:0]           rf_write_index_o,
  output logic [WIDTH-1:0]           rf_write_data_o,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_count_o
`ifdef WB_FORWARD_EN
  ,
  input  logic [DEPTH-1:0]           fwd_index_1_i,
  input  logic [DEPTH-1:0]           fwd_index_2_i,
  output logic                       fwd_hit_1_o,
  output logic                       fwd_hit_2_o,
  output logic [WIDTH-1:0]           fwd_data_1_o,
  output logic [WIDTH-1:0]           fwd_data_2_o
`endif
);

  localparam int unsigned EW  = WIDTH + DEPTH;
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EW-1:0]    fifo_rdata;
  logic [DEPTH-1:0] head_index;
  logic [WIDTH-1:0] head_data;

  wb_src_e          src;
  logic [DEPTH-1:0] gnt_index;
  logic [WIDTH-1:0] gnt_data;

  logic             we_q, we_d;
  logic [DEPTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             stall_q, stall_d;
  logic [SCW-1:0]   starve_q, starve_d;

  assign lu_ready_o = !fifo_full;
  assign fifo_push  = lu_valid_i && !fifo_full;
  assign head_index = fifo_rdata[EW-1 -: DEPTH];
  assign head_data  = fifo_rdata[WIDTH-1:0];

  writeback_arbiter_fifo #(
    .DATA_W (EW),
    .ADDR_W (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({lu_index_i, lu_data_i}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  // Grant selection: a stall cycle belongs to the FIFO; otherwise pipe wins.
  always_comb begin
    src       = WB_SRC_NONE;
    gnt_index = '0;
    gnt_data  = '0;
    if (stall_q) begin
      if (!fifo_empty) src = WB_SRC_LU;
    end else if (pipe_valid_i) begin
      src = WB_SRC_PIPE;
    end else if (!fifo_empty) begin
      src = WB_SRC_LU;
    end
    case (src)
      WB_SRC_PIPE: begin
        gnt_index = pipe_index_i;
        gnt_data  = pipe_data_i;
      end
      WB_SRC_LU: begin
        gnt_index = head_index;
        gnt_data  = head_data;
      end
      default: ;
    endcase
  end

  assign fifo_pop = (src == WB_SRC_LU);

  // Output register next-state; index 0 is consumed without a write.
  always_comb begin
    we_d   = WB_DISABLE;
    idx_d  = idx_q;
    data_d = data_q;
    if (src != WB_SRC_NONE && gnt_index != '0) begin
      we_d   = WB_ENABLE;
      idx_d  = gnt_index;
      data_d = gnt_data;
    end
  end

  // Starvation guard: count pipe wins over a waiting FIFO, force one drain slot.
  always_comb begin
    starve_d = starve_q;
    stall_d  = WB_DISABLE;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (src == WB_SRC_PIPE) begin
      if (starve_q == SCW'(STARVE_LIMIT - 1)) begin
        stall_d  = WB_ENABLE;
        starve_d = '0;
      end else begin
        starve_d = starve_q + SCW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  assign rf_write_enable_o = we_q;
  assign rf_write_index_o  = idx_q;
  assign rf_write_data_o   = data_q;
  assign pipe_stall_o      = stall_q;

`ifdef WB_FORWARD_EN
  // Bypass for the write the RF has not committed yet.
  assign fwd_hit_1_o  = we_q && (idx_q == fwd_index_1_i);
  assign fwd_hit_2_o  = we_q && (idx_q == fwd_index_2_i);
  assign fwd_data_1_o = data_q;
  assign fwd_data_2_o = data_q;
`else
  // Forwarding ports are absent in this build.
`endif

endmodule
